instruction_fetch_memory: RTL and testbench
===========================================

INSTRUCTION_FETCH_MEMORY -- requirements
Module: instruction_fetch_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address (PC) width.
REQ-003 SHALL have parameter DEPTH, default 64, number of instruction words; power of two, >=2.
REQ-004 SHALL have parameter NOP_WORD, default 32'hD503201F, fill/fault instruction.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  fetch request present.
REQ-008 req_ready  out  1  block accepts request this cycle.
REQ-009 req_pc  in  ADDR_W  byte address of instruction.
REQ-010 rsp_valid  out  1  response present.
REQ-011 rsp_ready  in  1  consumer accepts response.
REQ-012 rsp_instr  out  DATA_W  fetched instruction.
REQ-013 rsp_fault  out  2  bit0 misaligned, bit1 out-of-range.
REQ-014 flush  in  1  discard held response (branch redirect).
REQ-015 load_we  in  1  program-load write strobe.
REQ-016 load_idx  in  clog2(DEPTH)  word index for load.
REQ-017 load_data  in  DATA_W  word to write.
REQ-018 init_busy  out  1  memory clear in progress.

Function
REQ-019 Two-state FSM SHALL be used: INIT, RUN; INIT entered on reset.
REQ-020 INIT SHALL write NOP_WORD to one word per cycle, index 0..DEPTH-1, then go to RUN; duration exactly DEPTH cycles.
REQ-021 During INIT: init_busy=1, req_ready=0, load_we ignored.
REQ-022 In RUN: req_ready = !rsp_valid || rsp_ready (single output register, no bubble at full throughput).
REQ-023 Handshake: request accepted when req_valid && req_ready; response appears with rsp_valid=1 on the next cycle (latency 1).
REQ-024 Word index SHALL be req_pc >> 2; misaligned when req_pc[1:0]!=0; out-of-range when req_pc>>2 >= DEPTH; both bits may be set.
REQ-025 On any fault rsp_instr SHALL be NOP_WORD; otherwise the stored word.
REQ-026 While rsp_valid && !rsp_ready, rsp_instr and rsp_fault SHALL hold stable.
REQ-027 rsp_valid SHALL clear after rsp_ready handshake unless a new request is accepted that same cycle.
REQ-028 flush SHALL clear rsp_valid next cycle and block acceptance that cycle (req_ready=0 when flush=1); flush takes priority over handshakes.
REQ-029 load_we in RUN SHALL write load_data to load_idx at the clock edge.
REQ-030 Load and fetch of same index in same cycle: fetch returns the old word (read-before-write).
REQ-031 Memory contents SHALL persist across handshakes; only INIT and load_we modify them.

Reset
REQ-032 rst_n low SHALL asynchronously force: FSM=INIT, init index=0, rsp_valid=0, rsp_instr=0, rsp_fault=0, init_busy=1, req_ready=0.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from index 0 on release; in-flight response discarded.

Verification
REQ-034 Release reset, DEPTH=64 -> init_busy high exactly 64 cycles, then fetch PC 0x0 -> rsp_instr=0xD503201F, rsp_fault=0.
REQ-035 Load idx1=0x8B010022, fetch PC 0x4 -> next cycle rsp_valid=1, rsp_instr=0x8B010022; back-to-back PC 0x0,0x4 with rsp_ready=1 -> one response per cycle.
REQ-036 Fetch PC 0x6 -> rsp_fault=01, NOP; fetch PC 0x100 -> rsp_fault=10, NOP; PC 0x102 -> rsp_fault=11.
REQ-037 Hold rsp_ready=0 three cycles with req_valid=1 -> req_ready=0, rsp_instr stable; raise rsp_ready -> next request accepted that cycle.
REQ-038 Assert flush with rsp_valid=1 -> rsp_valid=0 next cycle, no request accepted that cycle.
REQ-039 Same-cycle load idx2=0xD1000333 and fetch PC 0x8 -> old word returned; repeat fetch -> 0xD1000333; pulse rst_n mid-INIT -> INIT restarts, 64 busy cycles.

Source files
------------

// File: rtl/instruction_fetch_memory.sv
// instruction_fetch_memory: word-addressed instruction store with NOP clear-on-reset and a single-entry fetch response register
module instruction_fetch_memory #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hD503201F
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [ADDR_W-1:0]        i_req_pc,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_W-1:0]        o_rsp_instr,
  output logic [1:0]               o_rsp_fault,
  input  logic                     i_flush,
  input  logic                     i_load_we,
  input  logic [$clog2(DEPTH)-1:0] i_load_idx,
  input  logic [DATA_W-1:0]        i_load_data,
  output logic                     o_init_busy
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t            r_state, w_next_state;
  logic [IW-1:0]     r_init_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_instr;
  logic [1:0]        r_rsp_fault;
  logic              w_busy, w_req_ready, w_accept, w_we;
  logic [IW-1:0]     w_widx, w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_fault;
  assign w_idx    = i_req_pc[IW+1:2];
  assign w_fault  = {|i_req_pc[ADDR_W-1:IW+2], |i_req_pc[1:0]};
  assign w_accept = i_req_valid && w_req_ready;
  assign o_req_ready = w_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_instr = r_rsp_instr;
  assign o_rsp_fault = r_rsp_fault;
  assign o_init_busy = w_busy;
  // state register: reset always restarts the memory clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= INIT;
    else r_state <= w_next_state;
  // next state, write-port steering and request backpressure
  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_req_ready  = 1'b0;
    w_we         = i_load_we;
    w_widx       = i_load_idx;
    w_wdata      = i_load_data;
    if (r_state == INIT) begin
      w_busy  = 1'b1;
      w_we    = 1'b1;
      w_widx  = r_init_idx;
      w_wdata = NOP_WORD;
      if (r_init_idx == IW'(DEPTH - 1)) w_next_state = RUN;
    end else begin
      w_req_ready = !i_flush && (!r_rsp_valid || i_rsp_ready);
    end
  end
  // clear pointer walks the array once per INIT pass and wraps to 0 on exit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_init_idx <= '0;
    else if (r_state == INIT) r_init_idx <= r_init_idx + 1'b1;
  // storage array; same-edge fetch sees the pre-write contents
  always_ff @(posedge clk)
    if (w_we) r_mem[w_widx] <= w_wdata;
  // response register: flush wins, then a new accept, then a drained handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_fault <= '0;
    end else if (i_flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_instr <= |w_fault ? NOP_WORD : r_mem[w_idx];
      r_rsp_fault <= w_fault;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
endmodule

// File: tb/tb_instruction_fetch_memory.sv
// tb_instruction_fetch_memory: directed scoreboard bench for instruction_fetch_memory
module tb_instruction_fetch_memory;
  localparam logic [31:0] NOP = 32'hD503201F;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, flush = 1'b0, load_we = 1'b0, init_busy;
  logic [31:0] req_pc = '0, rsp_instr, load_data = '0;
  logic [1:0]  rsp_fault;
  logic [5:0]  load_idx = '0;
  logic [31:0] model [64];
  logic [33:0] q [$];
  logic [33:0] held = '0;
  int          n_assert = 0, n_fail = 0;
  instruction_fetch_memory dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_pc(req_pc),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_instr(rsp_instr), .o_rsp_fault(rsp_fault),
    .i_flush(flush), .i_load_we(load_we), .i_load_idx(load_idx), .i_load_data(load_data), .o_init_busy(init_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nx();
    @(negedge clk);
    #1;
  endtask
  function automatic logic [33:0] exp_of(input logic [31:0] pc);
    logic [1:0] f;
    f = {(pc >> 2) >= 32'd64, pc[1:0] != 2'b00};
    return {f, (f != 2'b00) ? NOP : model[pc[7:2]]};
  endfunction
  task automatic pop_chk(input string tag);
    chk({tag, "_pending"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      held = q.pop_front();
      chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_instr"}, 64'(rsp_instr), 64'(held[31:0]));
      chk({tag, "_fault"}, 64'(rsp_fault), 64'(held[33:32]));
    end
  endtask
  task automatic fetch(input logic [31:0] pc, input string tag);
    req_valid = 1'b1; req_pc = pc; rsp_ready = 1'b1; #1;
    chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
    q.push_back(exp_of(pc));
    nx();
    req_valid = 1'b0;
    pop_chk(tag);
    nx();
    chk({tag, "_drain"}, 64'(rsp_valid), 64'd0);
  endtask
  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    #1;
    while (init_busy && cnt < 200) begin
      nx();
      cnt++;
    end
    chk(tag, 64'(cnt), 64'd64);
    foreach (model[i]) model[i] = NOP;
  endtask
  task automatic load(input logic [5:0] idx, input logic [31:0] data);
    load_we = 1'b1; load_idx = idx; load_data = data;
    nx();
    load_we = 1'b0;
    model[idx] = data;
  endtask
  initial begin
    foreach (model[i]) model[i] = NOP;
    #1 rst_n = 1'b0;
    nx();
    chk("rst_busy", 64'(init_busy), 64'd1);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_instr", 64'(rsp_instr), 64'd0);
    chk("rst_fault", 64'(rsp_fault), 64'd0);
    rst_n = 1'b1;
    wait_init("init_cycles");
    chk("run_ready", 64'(req_ready), 64'd1);
    fetch(32'h0, "pc0_nop");
    load(6'd1, 32'h8B010022);
    fetch(32'h4, "pc4_loaded");
    req_valid = 1'b1; req_pc = 32'h0; rsp_ready = 1'b1; #1;
    chk("b2b_rdy0", 64'(req_ready), 64'd1);
    q.push_back(exp_of(32'h0));
    nx();
    pop_chk("b2b0");
    req_pc = 32'h4; #1;
    chk("b2b_rdy1", 64'(req_ready), 64'd1);
    q.push_back(exp_of(32'h4));
    nx();
    req_valid = 1'b0;
    pop_chk("b2b1");
    nx();
    chk("b2b_drain", 64'(rsp_valid), 64'd0);
    fetch(32'h6, "misaligned");
    fetch(32'h100, "out_of_range");
    fetch(32'h102, "both_faults");
    req_valid = 1'b1; req_pc = 32'h4; rsp_ready = 1'b1; #1;
    chk("bp_rdy", 64'(req_ready), 64'd1);
    q.push_back(exp_of(32'h4));
    nx();
    pop_chk("bp_first");
    rsp_ready = 1'b0; req_pc = 32'h0; #1;
    chk("bp_stall_rdy", 64'(req_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      nx();
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_instr", 64'(rsp_instr), 64'(held[31:0]));
      chk("bp_hold_fault", 64'(rsp_fault), 64'(held[33:32]));
      chk("bp_hold_rdy", 64'(req_ready), 64'd0);
    end
    nx();
    chk("bp_hold_instr3", 64'(rsp_instr), 64'(held[31:0]));
    rsp_ready = 1'b1; #1;
    chk("bp_release_rdy", 64'(req_ready), 64'd1);
    q.push_back(exp_of(32'h0));
    nx();
    req_valid = 1'b0;
    pop_chk("bp_next");
    nx();
    chk("bp_drain", 64'(rsp_valid), 64'd0);
    req_valid = 1'b1; req_pc = 32'h4; rsp_ready = 1'b1; #1;
    q.push_back(exp_of(32'h4));
    nx();
    pop_chk("fl_pre");
    flush = 1'b1; rsp_ready = 1'b0; req_pc = 32'h0; #1;
    chk("fl_rdy", 64'(req_ready), 64'd0);
    nx();
    flush = 1'b0; req_valid = 1'b0;
    chk("fl_valid", 64'(rsp_valid), 64'd0);
    nx();
    chk("fl_no_accept", 64'(rsp_valid), 64'd0);
    req_valid = 1'b1; req_pc = 32'h8; rsp_ready = 1'b1;
    load_we = 1'b1; load_idx = 6'd2; load_data = 32'hD1000333; #1;
    q.push_back(exp_of(32'h8));
    model[2] = 32'hD1000333;
    nx();
    load_we = 1'b0;
    pop_chk("rbw_old");
    q.push_back(exp_of(32'h8));
    nx();
    req_valid = 1'b0;
    pop_chk("rbw_new");
    nx();
    req_valid = 1'b1; req_pc = 32'h4; rsp_ready = 1'b0; #1;
    q.push_back(exp_of(32'h4));
    nx();
    req_valid = 1'b0;
    pop_chk("inflight");
    rst_n = 1'b0; #1;
    chk("rst_run_valid", 64'(rsp_valid), 64'd0);
    chk("rst_run_busy", 64'(init_busy), 64'd1);
    nx();
    rst_n = 1'b1;
    repeat (10) nx();
    rst_n = 1'b0; #1;
    chk("rst_mid_busy", 64'(init_busy), 64'd1);
    nx();
    rst_n = 1'b1;
    wait_init("reinit_cycles");
    chk("reinit_valid", 64'(rsp_valid), 64'd0);
    fetch(32'h4, "reinit_cleared");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
